// File: rtl/sha_job_ctrl.sv
// sha_job_ctrl: sequences one HM_SHA_256 compression per accepted block and hands back the digest
module sha_job_ctrl #(
    parameter int ROUNDS = 64,
    parameter int CW     = 7
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                blk_valid,
    input  logic                blk_first,
    input  logic [15:0][31:0]   blk_data,
    output logic                blk_ready,
    input  logic                stall,
    input  logic                abort,
    output logic                hash_valid,
    input  logic                hash_ack,
    output logic [7:0][31:0]    hash_out,
    output logic                busy,
    output logic                sha_init,
    output logic                sha_clear,
    output logic                sha_halt,
    output logic [CW-1:0]       sha_count,
    output logic [15:0][31:0]   sha_data,
    input  logic [7:0][31:0]    sha_hash
);

    typedef enum logic [2:0] {IDLE, INIT, SETTLE, RUN, CAPTURE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                first_q, first_d;
    logic [15:0][31:0]   data_q, data_d;
    logic [7:0][31:0]    hash_q, hash_d;
    logic                last;

    assign last = cnt_q == CW'(ROUNDS - 1);

    // State, round counter, latched block and captured digest
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            data_q  <= '0;
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            data_q  <= data_d;
            hash_q  <= hash_d;
        end
    end

    // Next state; abort overrides everything and leaves the block and digest registers untouched
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        data_d  = data_q;
        hash_d  = hash_q;
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    state_d = INIT;
                    first_d = blk_first;
                    data_d  = blk_data;
                end
            end
            INIT:   state_d = SETTLE;
            SETTLE: state_d = RUN;
            RUN: begin
                if (!stall) begin
                    state_d = last ? CAPTURE : RUN;
                    cnt_d   = last ? cnt_q : cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                hash_d  = sha_hash;
                cnt_d   = '0;
                state_d = DONE;
            end
            DONE:    state_d = hash_ack ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            first_d = first_q;
            data_d  = data_q;
            hash_d  = hash_q;
        end
    end

    // Output decode; only the halt release in RUN looks at stall so the core freezes in the same cycle
    always_comb begin
        blk_ready  = state_q == IDLE;
        busy       = state_q != IDLE;
        hash_valid = state_q == DONE;
        sha_init   = state_q == INIT && first_q;
        sha_clear  = state_q == INIT || state_q == SETTLE || state_q == RUN || state_q == CAPTURE;
        sha_halt   = !(state_q == RUN && !stall);
        sha_count  = cnt_q;
        sha_data   = data_q;
        hash_out   = hash_q;
    end

endmodule

// File: tb/tb_sha_job_ctrl.sv
// tb_sha_job_ctrl: drives sha_job_ctrl against a round-level SHA-256 core model and checks timing and digests
module tb_sha_job_ctrl;

    localparam int ROUNDS = 64;
    localparam int CW     = 7;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [7:0][31:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                       32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    localparam logic [7:0][31:0] ABC_D = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                          32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
    localparam logic [7:0][31:0] TWO_D = {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                                          32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic blk_valid = 1'b0;
    logic blk_first = 1'b0;
    logic stall = 1'b0;
    logic abort = 1'b0;
    logic hash_ack = 1'b0;
    logic [15:0][31:0] blk_data = '0;
    logic blk_ready, hash_valid, busy, sha_init, sha_clear, sha_halt;
    logic [7:0][31:0] hash_out, sha_hash;
    logic [CW-1:0] sha_count;
    logic [15:0][31:0] sha_data;

    int checks = 0;
    int passes = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;

    sha_job_ctrl #(.ROUNDS(ROUNDS), .CW(CW)) dut (
        .clk(clk), .n_rst(n_rst), .blk_valid(blk_valid), .blk_first(blk_first), .blk_data(blk_data),
        .blk_ready(blk_ready), .stall(stall), .abort(abort), .hash_valid(hash_valid), .hash_ack(hash_ack),
        .hash_out(hash_out), .busy(busy), .sha_init(sha_init), .sha_clear(sha_clear), .sha_halt(sha_halt),
        .sha_count(sha_count), .sha_data(sha_data), .sha_hash(sha_hash));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0][31:0] sched(input logic [15:0][31:0] m);
        logic [63:0][31:0] w;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) w[i] = m[i];
            else w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
                        + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
        end
        return w;
    endfunction

    function automatic logic [7:0][31:0] rnd(input logic [7:0][31:0] v, input int t, input logic [31:0] w);
        logic [31:0] t1, t2;
        logic [7:0][31:0] r;
        t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w;
        t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        r = {v[6:0], t1 + t2};
        r[4] = v[3] + t1;
        return r;
    endfunction

    function automatic logic [7:0][31:0] add8(input logic [7:0][31:0] a, input logic [7:0][31:0] b);
        logic [7:0][31:0] r;
        for (int i = 0; i < 8; i++) r[i] = a[i] + b[i];
        return r;
    endfunction

    // Whole-block reference: digest after compressing m onto chaining value h
    function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] h, input logic [15:0][31:0] m);
        logic [63:0][31:0] w;
        logic [7:0][31:0] v;
        w = sched(m);
        v = h;
        for (int t = 0; t < 64; t++) v = rnd(v, t, w[t]);
        return add8(h, v);
    endfunction

    // Core model: one round per unhalted edge, chaining value folded in after the last round
    logic [7:0][31:0] core_h, core_v, core_nv;
    logic [63:0][31:0] core_w;
    assign core_w   = sched(sha_data);
    assign core_nv  = rnd(sha_count == '0 ? core_h : core_v, int'(sha_count), core_w[sha_count[5:0]]);
    assign sha_hash = core_h;

    always @(posedge clk) begin
        if (sha_init) core_h <= IV;
        else if (!sha_halt) begin
            core_v <= core_nv;
            if (sha_count == CW'(ROUNDS - 1)) core_h <= add8(core_h, core_nv);
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, blk_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_hvalid"}, hash_valid, 1'b0);
        chk({tag, "_hout"}, hash_out, '0);
        chk({tag, "_init"}, sha_init, 1'b0);
        chk({tag, "_clear"}, sha_clear, 1'b0);
        chk({tag, "_halt"}, sha_halt, 1'b1);
        chk({tag, "_count"}, sha_count, '0);
        chk({tag, "_data"}, sha_data, '0);
    endtask

    // One block from accept to ack; called in the low clock phase with the DUT idle
    task automatic run_job(input logic [15:0][31:0] m, input logic first, input int st_at, input int st_len,
                           input bit noise, input int ack_dly, input logic [7:0][31:0] exp, input bit chkd,
                           input string tag);
        int k, ran, s, left, bad;
        bit in_run;
        logic e_halt;
        logic [CW-1:0] e_cnt;
        logic [7:0][31:0] h0;
        logic [15:0][31:0] d0;
        ran = 0; s = 0; left = st_len; bad = 0; k = 0;
        chk({tag, "_ready"}, blk_ready, 1'b1);
        blk_valid = 1'b1; blk_first = first; blk_data = m; t0 = cyc;
        @(negedge clk);
        blk_valid = 1'b0; blk_first = 1'($urandom_range(0, 1)); blk_data = {16{$urandom}};
        while (k < 400) begin
            k = cyc - t0;
            in_run = k >= 3 && ran < ROUNDS;
            stall = in_run ? (ran == st_at && left > 0) : (noise && $urandom_range(0, 1) == 1);
            if (in_run && stall) begin left--; s++; end
            #1;
            if (hash_valid) break;
            e_halt = in_run ? stall : 1'b1;
            e_cnt = k <= 2 ? '0 : in_run ? CW'(ran) : CW'(ROUNDS - 1);
            bad += int'(sha_halt !== e_halt) + int'(sha_count !== e_cnt) + int'(sha_init !== (k == 1 && first))
                 + int'(sha_clear !== 1'b1) + int'(busy !== 1'b1) + int'(blk_ready !== 1'b0) + int'(sha_data !== m);
            if (in_run && !stall) ran++;
            @(negedge clk);
        end
        stall = 1'b0;
        chk({tag, "_latency"}, k, 68 + s);
        chk({tag, "_seq"}, bad, 0);
        if (chkd) chk({tag, "_digest"}, hash_out, exp);
        h0 = hash_out; d0 = sha_data; bad = 0;
        repeat (ack_dly) begin
            blk_valid = 1'b1; blk_first = 1'b1; blk_data = {16{$urandom}};
            #1;
            bad += int'(hash_valid !== 1'b1) + int'(hash_out !== h0) + int'(blk_ready !== 1'b0) + int'(busy !== 1'b1);
            @(negedge clk);
        end
        blk_valid = 1'b1; hash_ack = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0; hash_ack = 1'b0;
        #1;
        chk({tag, "_hold"}, bad, 0);
        chk({tag, "_ack_valid"}, hash_valid, 1'b0);
        chk({tag, "_ack_ready"}, blk_ready, 1'b1);
        chk({tag, "_ack_data"}, sha_data, d0);
        chk({tag, "_ack_hout"}, hash_out, h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0][31:0] abc, b1, b2, m;
        logic [7:0][31:0] h, hsave;
        int bad, nblk;
        abc = '0; abc[0] = 32'h61626380; abc[15] = 32'h00000018;
        b1 = '0;
        for (int i = 0; i < 14; i++) b1[i] = {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)};
        b1[14] = 32'h80000000;
        b2 = '0; b2[15] = 32'h000001c0;

        #1;
        chk_reset("por");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk_reset("post_rel");

        blk_valid = 1'b1; blk_first = 1'b1; blk_data = abc;
        @(negedge clk);
        blk_valid = 1'b0;
        bad = 0;
        while (!(sha_count == 30 && !sha_halt) && bad < 100) begin @(negedge clk); bad++; end
        chk("midrst_reach", bad < 100, 1'b1);
        #2 n_rst = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clk);
        @(negedge clk) n_rst = 1'b1;
        #1;

        run_job(abc, 1'b1, -1, 0, 1'b0, 0, ABC_D, 1'b1, "abc");
        run_job(abc, 1'b1, 10, 5, 1'b0, 1, ABC_D, 1'b1, "abc_stall");
        run_job(b1, 1'b1, -1, 0, 1'b1, 2, compress(IV, b1), 1'b1, "two_b1");
        run_job(b2, 1'b0, 33, 2, 1'b1, 0, TWO_D, 1'b1, "two_b2");

        hsave = hash_out;
        blk_valid = 1'b1; blk_first = 1'b1; blk_data = abc;
        @(negedge clk);
        blk_valid = 1'b0;
        bad = 0;
        while (!(sha_count == 40 && !sha_halt) && bad < 100) begin @(negedge clk); bad++; end
        chk("abort_reach", bad < 100, 1'b1);
        abort = 1'b1; stall = 1'b1; hash_ack = 1'b1; blk_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; stall = 1'b0; hash_ack = 1'b0; blk_valid = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", blk_ready, 1'b1);
        chk("abort_count", sha_count, '0);
        chk("abort_clear", sha_clear, 1'b0);
        bad = 0;
        repeat (80) begin @(negedge clk); bad += int'(hash_valid !== 1'b0) + int'(busy !== 1'b0); end
        chk("abort_quiet", bad, 0);
        chk("abort_hout", hash_out, hsave);
        run_job(abc, 1'b1, -1, 0, 1'b1, 0, ABC_D, 1'b1, "post_abort");

        blk_valid = 1'b1; blk_first = 1'b1; blk_data = abc; abort = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0; abort = 1'b0;
        #1;
        chk("abort_idle_busy", busy, 1'b0);
        chk("abort_idle_ready", blk_ready, 1'b1);
        m = {16{$urandom}};
        run_job(m, 1'b0, $urandom_range(0, 63), 3, 1'b1, 1, '0, 1'b0, "chain_after_abort");

        run_job(abc, 1'b1, -1, 0, 1'b0, 20, ABC_D, 1'b1, "ack_hold");

        for (int n = 0; n < 5; n++) begin
            h = IV;
            nblk = $urandom_range(1, 3);
            for (int b = 0; b < nblk; b++) begin
                for (int i = 0; i < 16; i++) m[i] = $urandom;
                h = compress(h, m);
                run_job(m, b == 0, $urandom_range(0, 63), $urandom_range(0, 4), 1'b1, $urandom_range(0, 5),
                        h, 1'b1, $sformatf("rnd%0d_%0d", n, b));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
